// File: rtl/mem_port_arbiter.sv
// Arbiter for the single external memory port shared by instruction fetch and
// the MEM-stage load/store unit; sequences each access and drives pipeline stalls.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_W-1:0]     if_addr,
  output logic [DATA_W-1:0]     if_rdata,
  output logic                  if_done,
  input  logic                  mem_req,
  input  logic                  mem_we,
  input  logic [ADDR_W-1:0]     mem_addr,
  input  logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W/8-1:0]   mem_wmask,
  output logic [DATA_W-1:0]     mem_rdata,
  output logic                  mem_done,
  input  logic                  flush,
  output logic                  ext_req,
  output logic                  ext_we,
  output logic [ADDR_W-1:0]     ext_addr,
  output logic [DATA_W-1:0]     ext_wdata,
  output logic [DATA_W/8-1:0]   ext_wmask,
  input  logic [DATA_W-1:0]     ext_rdata,
  input  logic                  ext_ack,
  output logic [4:0]            stall,
  output logic                  err_timeout,
  output logic [1:0]            fsm_state
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TLIM    = CW'(TIMEOUT);
  localparam logic [CW-1:0] TLIM_M1 = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] TONE    = CW'(1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    IF_WAIT  = 2'd1,
    MEM_WAIT = 2'd2,
    IF_DROP  = 2'd3
  } state_t;

  state_t          state;
  logic [CW-1:0]   tcount;
  logic            mem_go;
  logic            if_go;
  logic            counting;

  // A requester whose done pulse is showing is not re-granted in that cycle.
  assign mem_go   = mem_req & ~mem_done;
  assign if_go    = if_req & ~flush & ~if_done;
  assign counting = (state != IDLE) & ext_req & ~ext_ack & (tcount != TLIM);

  assign fsm_state = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      ext_req     <= 1'b0;
      ext_we      <= 1'b0;
      ext_addr    <= '0;
      ext_wdata   <= '0;
      ext_wmask   <= '0;
      if_rdata    <= '0;
      mem_rdata   <= '0;
      if_done     <= 1'b0;
      mem_done    <= 1'b0;
      err_timeout <= 1'b0;
      tcount      <= '0;
    end else begin
      if_done  <= 1'b0;
      mem_done <= 1'b0;

      // Saturating wait counter; the access itself is never aborted.
      if (counting) begin
        tcount <= tcount + TONE;
        if (tcount == TLIM_M1) begin
          err_timeout <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (mem_go) begin
            state     <= MEM_WAIT;
            ext_req   <= 1'b1;
            ext_we    <= mem_we;
            ext_addr  <= mem_addr;
            ext_wdata <= mem_we ? mem_wdata : '0;
            ext_wmask <= mem_we ? mem_wmask : '0;
            tcount    <= '0;
          end else if (if_go) begin
            state     <= IF_WAIT;
            ext_req   <= 1'b1;
            ext_we    <= 1'b0;
            ext_addr  <= if_addr;
            ext_wdata <= '0;
            ext_wmask <= '0;
            tcount    <= '0;
          end
        end

        IF_WAIT: begin
          if (ext_ack) begin
            ext_req <= 1'b0;
            if (flush) begin
              state  <= IF_DROP;
              tcount <= '0;
            end else begin
              if_rdata <= ext_rdata;
              if_done  <= 1'b1;
              state    <= IDLE;
            end
          end else if (flush) begin
            state  <= IF_DROP;
            tcount <= '0;
          end
        end

        MEM_WAIT: begin
          if (ext_ack) begin
            ext_req   <= 1'b0;
            mem_rdata <= ext_rdata;
            mem_done  <= 1'b1;
            state     <= IDLE;
          end
        end

        IF_DROP: begin
          // Entered with ext_req already low when the ack coincided with flush.
          if (ext_ack || !ext_req) begin
            ext_req <= 1'b0;
            state   <= IDLE;
          end
        end

        default: begin
          state   <= IDLE;
          ext_req <= 1'b0;
        end
      endcase
    end
  end

  // MEM stall freezes everything up to EX_MEM; a fetch stall only PC and IF_ID.
  always_comb begin
    stall = 5'b00000;
    if (mem_req & ~mem_done) begin
      stall = 5'b01111;
    end else if (if_req & ~if_done) begin
      stall = 5'b00011;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: reset vector table, scripted access sequences,
// an acking memory responder and a scoreboard of expected ext/done results.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = DW / 8;
  localparam int EW = 1 + MW + AW + DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_done;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [MW-1:0] mem_wmask;
  logic [DW-1:0] mem_rdata;
  logic          mem_done;
  logic          flush;
  logic          ext_req;
  logic          ext_we;
  logic [AW-1:0] ext_addr;
  logic [DW-1:0] ext_wdata;
  logic [MW-1:0] ext_wmask;
  logic [DW-1:0] ext_rdata;
  logic          ext_ack;
  logic [4:0]    stall;
  logic          err_timeout;
  logic [1:0]    fsm_state;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_rdata(mem_rdata), .mem_done(mem_done),
    .flush(flush),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_wmask(ext_wmask), .ext_rdata(ext_rdata), .ext_ack(ext_ack),
    .stall(stall), .err_timeout(err_timeout), .fsm_state(fsm_state)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Scoreboard: {we, wmask, addr, wdata} per external access, plus read data.
  logic [EW-1:0] exp_ext_q[$];
  logic [DW-1:0] exp_if_q[$];
  logic [DW-1:0] exp_mem_q[$];
  logic [DW-1:0] resp_q[$];

  int   ack_delay = 0;
  bit   resp_en   = 1'b1;
  int   ack_cnt   = 0;
  logic prev_req  = 1'b0;
  logic [EW-1:0] mon_e;

  typedef struct {
    logic       m;
    logic       i;
    logic       f;
    logic [4:0] s;
  } vec_t;
  vec_t tbl[6];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [EW-1:0] pack_ext(input logic we, input logic [MW-1:0] wm,
                                             input logic [AW-1:0] a, input logic [DW-1:0] wd);
    return {we, wm, a, wd};
  endfunction

  task automatic monitor_step();
    if (!rst) begin
      prev_req = 1'b0;
    end else begin
      if (ext_req && !prev_req) begin
        if (exp_ext_q.size() == 0) begin
          check("ext_req_unexpected", ext_req, 0);
        end else begin
          mon_e = exp_ext_q.pop_front();
          check("ext_we", ext_we, mon_e[EW-1]);
          check("ext_wmask", ext_wmask, mon_e[EW-2 -: MW]);
          check("ext_addr", ext_addr, mon_e[AW+DW-1 -: AW]);
          check("ext_wdata", ext_wdata, mon_e[DW-1:0]);
        end
      end
      prev_req = ext_req;
      if (if_done) begin
        if (exp_if_q.size() == 0) check("if_done_unexpected", if_done, 0);
        else check("if_rdata", if_rdata, exp_if_q.pop_front());
      end
      if (mem_done) begin
        if (exp_mem_q.size() == 0) check("mem_done_unexpected", mem_done, 0);
        else check("mem_rdata", mem_rdata, exp_mem_q.pop_front());
      end
    end
  endtask

  task automatic respond();
    if (!rst) begin
      ext_ack = 1'b0;
      ack_cnt = 0;
    end else if (ext_ack) begin
      ext_ack = 1'b0;
      ack_cnt = 0;
    end else if (ext_req && resp_en) begin
      if (ack_cnt >= ack_delay) begin
        ext_ack = 1'b1;
        if (resp_q.size() > 0) ext_rdata = resp_q.pop_front();
        else ext_rdata = 32'hBAD0BAD0;
      end else begin
        ack_cnt++;
      end
    end
  endtask

  task automatic next_cycle();
    @(negedge clk);
    monitor_step();
    respond();
  endtask

  task automatic wait_done(input bit is_mem, input string name);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      next_cycle();
      hit = is_mem ? mem_done : if_done;
    end
    check(name, hit, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; ext_ack = 1'b0; ext_rdata = '0;
    if_req = 1'b0; if_addr = '0; flush = 1'b0;
    mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wmask = '0;

    // Under reset the dones are 0, so stall depends on the requests alone.
    tbl[0] = '{m: 1'b0, i: 1'b0, f: 1'b0, s: 5'b00000};
    tbl[1] = '{m: 1'b1, i: 1'b0, f: 1'b0, s: 5'b01111};
    tbl[2] = '{m: 1'b0, i: 1'b1, f: 1'b0, s: 5'b00011};
    tbl[3] = '{m: 1'b1, i: 1'b1, f: 1'b0, s: 5'b01111};
    tbl[4] = '{m: 1'b0, i: 1'b1, f: 1'b1, s: 5'b00011};
    tbl[5] = '{m: 1'b1, i: 1'b1, f: 1'b1, s: 5'b01111};
    #2;
    for (int r = 0; r < 6; r++) begin
      mem_req = tbl[r].m; if_req = tbl[r].i; flush = tbl[r].f;
      #1;
      check($sformatf("stall_row%0d", r), stall, tbl[r].s);
    end
    mem_req = 1'b0; if_req = 1'b0; flush = 1'b0;
    #1;
    check("rst_ext_req", ext_req, 0);
    check("rst_ext_addr", ext_addr, 0);
    check("rst_if_done", if_done, 0);
    check("rst_mem_done", mem_done, 0);
    check("rst_if_rdata", if_rdata, 0);
    check("rst_mem_rdata", mem_rdata, 0);
    check("rst_err", err_timeout, 0);
    check("rst_state", fsm_state, 0);
    @(negedge clk); #2 rst = 1'b1;
    next_cycle();

    // Fetch with ack three cycles into the wait.
    ack_delay = 3;
    resp_q.push_back(32'h00500093);
    exp_ext_q.push_back(pack_ext(1'b0, 4'h0, 32'h100, 32'h0));
    exp_if_q.push_back(32'h00500093);
    if_req = 1'b1; if_addr = 32'h100;
    for (int k = 1; k <= 4; k++) begin
      next_cycle();
      check("t1_stall_wait", stall, 5'b00011);
    end
    wait_done(1'b0, "t1_if_done");
    check("t1_stall_done", stall, 5'b00000);
    if_req = 1'b0;
    next_cycle();
    check("t1_done_pulse", if_done, 0);

    // Simultaneous store and fetch: store goes first.
    ack_delay = 1;
    resp_q.push_back(32'h0);
    resp_q.push_back(32'h00000013);
    exp_ext_q.push_back(pack_ext(1'b1, 4'hF, 32'h2000, 32'hDEADBEEF));
    exp_ext_q.push_back(pack_ext(1'b0, 4'h0, 32'h300, 32'h0));
    exp_mem_q.push_back(32'h0);
    exp_if_q.push_back(32'h00000013);
    if_req = 1'b1; if_addr = 32'h300;
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h2000; mem_wdata = 32'hDEADBEEF; mem_wmask = 4'hF;
    next_cycle();
    check("t2_stall_mem", stall, 5'b01111);
    check("t2_state_mem", fsm_state, 2'd2);
    wait_done(1'b1, "t2_mem_done");
    check("t2_stall_if", stall, 5'b00011);
    mem_req = 1'b0; mem_we = 1'b0; mem_wdata = '0; mem_wmask = '0;
    wait_done(1'b0, "t2_if_done");
    if_req = 1'b0;
    next_cycle();

    // Flush one cycle into a fetch; the late data must be dropped.
    ack_delay = 3;
    resp_q.push_back(32'h12345678);
    exp_ext_q.push_back(pack_ext(1'b0, 4'h0, 32'h104, 32'h0));
    if_req = 1'b1; if_addr = 32'h104;
    next_cycle();
    flush = 1'b1;
    next_cycle();
    check("t3_state_drop", fsm_state, 2'd3);
    flush = 1'b0; if_addr = 32'h200;
    resp_q.push_back(32'h00000297);
    exp_ext_q.push_back(pack_ext(1'b0, 4'h0, 32'h200, 32'h0));
    exp_if_q.push_back(32'h00000297);
    next_cycle();
    check("t3_state_drop_hold", fsm_state, 2'd3);
    next_cycle();
    next_cycle();
    check("t3_state_idle", fsm_state, 2'd0);
    check("t3_no_if_done", if_done, 0);
    wait_done(1'b0, "t3_refetch_done");
    if_req = 1'b0;
    next_cycle();

    // Load acked in its first wait cycle.
    ack_delay = 0;
    resp_q.push_back(32'hCAFEF00D);
    exp_ext_q.push_back(pack_ext(1'b0, 4'h0, 32'h3000, 32'h0));
    exp_mem_q.push_back(32'hCAFEF00D);
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h3000; mem_wdata = '0; mem_wmask = 4'hF;
    next_cycle();
    check("t6_req_up", ext_req, 1);
    check("t6_no_early_done", mem_done, 0);
    next_cycle();
    check("t6_done_2cyc", mem_done, 1);
    mem_req = 1'b0; mem_wmask = '0;
    next_cycle();
    check("t6_done_pulse", mem_done, 0);

    // Ack withheld six cycles with a timeout of four.
    ack_delay = 6;
    resp_q.push_back(32'h0BADF00D);
    exp_ext_q.push_back(pack_ext(1'b0, 4'h0, 32'h5000, 32'h0));
    exp_mem_q.push_back(32'h0BADF00D);
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h5000;
    for (int k = 1; k <= 4; k++) begin
      next_cycle();
      check($sformatf("t4_err_low_%0d", k), err_timeout, 0);
    end
    next_cycle();
    check("t4_err_set", err_timeout, 1);
    wait_done(1'b1, "t4_late_done");
    mem_req = 1'b0;
    next_cycle();
    check("t4_err_sticky", err_timeout, 1);

    // Reset in the middle of a load, then the load is re-issued.
    resp_en = 1'b0;
    exp_ext_q.push_back(pack_ext(1'b0, 4'h0, 32'h4000, 32'h0));
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h4000;
    next_cycle();
    next_cycle();
    check("t5_state_wait", fsm_state, 2'd2);
    #2 rst = 1'b0; mem_req = 1'b0; if_req = 1'b0;
    #1;
    check("t5_ext_req_low", ext_req, 0);
    check("t5_mem_done_low", mem_done, 0);
    check("t5_if_done_low", if_done, 0);
    check("t5_stall_zero", stall, 5'b00000);
    check("t5_state_idle", fsm_state, 2'd0);
    check("t5_err_cleared", err_timeout, 0);
    next_cycle();
    #2 rst = 1'b1;
    next_cycle();
    resp_en = 1'b1; ack_delay = 1;
    resp_q.push_back(32'h0000ABCD);
    exp_ext_q.push_back(pack_ext(1'b0, 4'h0, 32'h4000, 32'h0));
    exp_mem_q.push_back(32'h0000ABCD);
    mem_req = 1'b1;
    wait_done(1'b1, "t5_reissue_done");
    mem_req = 1'b0;
    next_cycle();
    next_cycle();

    check("ext_q_drained", exp_ext_q.size(), 0);
    check("if_q_drained", exp_if_q.size(), 0);
    check("mem_q_drained", exp_mem_q.size(), 0);
    check("resp_q_drained", resp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
